// File: rtl/conv_job_scheduler.sv
// Job sequencer for the float/fixed converter bank: parses a command header,
// gathers payload beats, launches one engine, waits for done and emits the result.
module conv_job_scheduler #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [47:0]  fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rden,
  output logic [191:0] op_data,
  output logic [2:0]   op_sel,
  output logic [5:0]   eng_en,
  input  logic [5:0]   eng_done,
  input  logic [95:0]  res_data,
  output logic [47:0]  out_data,
  output logic         out_wren,
  input  logic         out_full,
  output logic         busy,
  output logic         err_illegal,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t          state;
  logic            rd_valid;
  logic [2:0]      rd_cnt;
  logic [1:0]      ld_cnt;
  logic [1:0]      pbeats;
  logic            rbeats;
  logic            legal;
  logic [5:0]      sel_mask;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;
  logic [95:0]     res_q;
  logic            emit_idx;
  logic            done_hit;
  logic            timeout_hit;

  // HDR always has a read outstanding; payload reads may already issue there.
  always_comb begin
    fifo_rden = 1'b0;
    case (state)
      S_IDLE, S_HDR: fifo_rden = !fifo_empty && !rstn;
      S_LOAD:        fifo_rden = !fifo_empty && !rstn && (rd_cnt <= {1'b0, pbeats});
      default:       fifo_rden = 1'b0;
    endcase
  end

  assign done_hit    = |(eng_done & sel_mask);
  assign to_next     = to_cnt + TO_W'(1);
  // Timeout flags during the last WAIT cycle itself so a coincident done can win.
  assign timeout_hit = (state == S_WAIT) && !done_hit && (to_next == TO_W'(TIMEOUT));
  assign err_timeout = timeout_hit;
  assign out_wren    = (state == S_EMIT) && !out_full;
  assign out_data    = (rbeats && !emit_idx) ? res_q[95:48] : res_q[47:0];
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= S_IDLE;
      rd_valid    <= 1'b0;
      rd_cnt      <= '0;
      ld_cnt      <= '0;
      pbeats      <= '0;
      rbeats      <= 1'b0;
      legal       <= 1'b0;
      sel_mask    <= '0;
      to_cnt      <= '0;
      res_q       <= '0;
      emit_idx    <= 1'b0;
      op_data     <= '0;
      op_sel      <= '0;
      eng_en      <= '0;
      err_illegal <= 1'b0;
    end else begin
      rd_valid    <= fifo_rden;
      eng_en      <= '0;
      err_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_rden) state <= S_HDR;
        end
        S_HDR: begin
          op_sel   <= fifo_dout[47:45];
          pbeats   <= fifo_dout[44:43];
          rbeats   <= fifo_dout[42];
          legal    <= (fifo_dout[47:45] <= 3'd5);
          sel_mask <= 6'b000001 << fifo_dout[47:45];
          op_data  <= '0;
          rd_cnt   <= {2'b00, fifo_rden};
          ld_cnt   <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          if (fifo_rden) rd_cnt <= rd_cnt + 3'd1;
          if (rd_valid) begin
            op_data <= {op_data[143:0], fifo_dout};
            ld_cnt  <= ld_cnt + 2'd1;
            if (ld_cnt == pbeats) begin
              if (legal) begin
                eng_en <= sel_mask;
                state  <= S_FIRE;
              end else begin
                err_illegal <= 1'b1;
                state       <= S_IDLE;
              end
            end
          end
        end
        S_FIRE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (done_hit) begin
            res_q    <= res_data;
            emit_idx <= 1'b0;
            state    <= S_EMIT;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_next;
          end
        end
        S_EMIT: begin
          if (out_wren) begin
            if (rbeats && !emit_idx) emit_idx <= 1'b1;
            else                     state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: FIFO/engine models around the DUT,
// negedge event log, hand-computed expectations.
module tb_conv_job_scheduler;

  logic         clk;
  logic         rstn;
  logic [47:0]  fifo_dout;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [191:0] op_data;
  logic [2:0]   op_sel;
  logic [5:0]   eng_en;
  logic [5:0]   eng_done;
  logic [95:0]  res_data;
  logic [47:0]  out_data;
  logic         out_wren;
  logic         out_full;
  logic         busy;
  logic         err_illegal;
  logic         err_timeout;

  conv_job_scheduler #(.TIMEOUT(16), .TO_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .op_data(op_data), .op_sel(op_sel), .eng_en(eng_en), .eng_done(eng_done),
    .res_data(res_data), .out_data(out_data), .out_wren(out_wren), .out_full(out_full),
    .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // environment state
  int           cyc = 0;
  logic [47:0]  fq[$];
  logic         hold_empty = 1'b0;
  logic         toggle_mode = 1'b0;
  logic         rd_now;
  logic         auto_done = 1'b0;
  int           done_dly = 0;
  logic [95:0]  done_res = '0;
  int           done_cyc = -1;
  logic [5:0]   done_mask = '0;
  logic [95:0]  done_val = '0;
  int           stray_cyc = -1;
  logic [5:0]   stray_mask = '0;
  logic [95:0]  stray_res = '0;

  // event log
  int           rdq[$];
  logic [5:0]   enq[$];
  logic [191:0] eopq[$];
  int           ecq[$];
  logic [47:0]  oq[$];
  int           wcq[$];
  int           ill_n = 0;
  int           to_n = 0;
  int           to_cyc = -1;
  int           fall_cyc = -1;
  logic         prev_busy = 1'b0;
  int           rd_at_en[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] hdr(input logic [2:0] id, input logic [1:0] pbm1, input logic rbm1);
    hdr = {id, pbm1, rbm1, 42'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Input FIFO and engine bank model: data appears 1 time unit after a read edge.
  initial begin
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    eng_done   = '0;
    res_data   = '0;
    forever begin
      @(posedge clk);
      rd_now = fifo_rden;
      #1;
      cyc++;
      if (rd_now && fq.size() > 0) fifo_dout = fq.pop_front();
      hold_empty = toggle_mode ? !hold_empty : 1'b0;
      fifo_empty = hold_empty || (fq.size() == 0);
      eng_done = '0;
      if (cyc == done_cyc) begin
        eng_done = done_mask;
        res_data = done_val;
      end
      if (cyc == stray_cyc) begin
        eng_done = eng_done | stray_mask;
        res_data = stray_res;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_rden) rdq.push_back(cyc);
      if (eng_en != '0) begin
        enq.push_back(eng_en);
        eopq.push_back(op_data);
        ecq.push_back(cyc);
        rd_at_en.push_back(rdq.size());
        if (auto_done) begin
          done_cyc  = cyc + done_dly;
          done_mask = eng_en;
          done_val  = done_res;
        end
      end
      if (err_illegal) ill_n++;
      if (err_timeout) begin
        to_n++;
        to_cyc = cyc;
      end
      if (out_wren) begin
        oq.push_back(out_data);
        wcq.push_back(cyc);
      end
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
    end
  end

  task automatic wait_en(input int n, input int maxc);
    int k = 0;
    while (enq.size() < n && k < maxc) begin
      step();
      k++;
    end
    check("en_seen", enq.size() >= n, 1);
  endtask

  task automatic wait_wr(input int n, input int maxc);
    int k = 0;
    while (oq.size() < n && k < maxc) begin
      step();
      k++;
    end
    check("wr_seen", oq.size() >= n, 1);
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      step();
      k++;
    end
    check("idle_seen", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  int r0, e0, o0, i0, t0;
  logic [95:0] res1, res2, res4, res5a, res5b, res6;
  logic [47:0] p6;

  initial begin
    rstn     = 1'b1;
    out_full = 1'b0;
    res1  = {48'h1234_5678_9ABC, 48'h0000_0001_8000};
    res2  = {48'h0, 48'h0000_2222_0002};
    res4  = {48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333};
    res5a = {48'h0, 48'h0000_5555_0005};
    res5b = {48'h0, 48'h0000_3333_0003};
    res6  = {48'h0, 48'h0000_6666_0006};
    p6    = 48'h0000_0000_0666;

    // reset with a job already waiting: nothing may be read while held in reset
    step();
    fq.push_back(hdr(3'd0, 2'd0, 1'b0));
    fq.push_back(48'h0000_3FC0_0000);
    step(); step(); step();
    check("rst_ctrl", {eng_en, op_sel, out_wren, busy, err_illegal, err_timeout, fifo_rden}, 0);
    check("rst_op", op_data, 0);
    check("rst_out", out_data, 0);

    // single job, engine 0, done 5 cycles after launch
    r0 = rdq.size(); e0 = enq.size(); o0 = oq.size();
    auto_done = 1'b1; done_dly = 5; done_res = res1;
    rstn = 1'b0;
    wait_wr(o0 + 1, 60);
    wait_idle(20);
    check("t1_en_n", enq.size() - e0, 1);
    check("t1_en", enq[e0], 6'b000001);
    check("t1_op", eopq[e0], {144'd0, 48'h0000_3FC0_0000});
    check("t1_wr_n", oq.size() - o0, 1);
    check("t1_out", oq[o0], 48'h0000_0001_8000);
    check("t1_rd_n", rdq.size() - r0, 2);
    check("t1_pay_rd", rdq[r0 + 1] - rdq[r0], 1);
    check("t1_en_lat", ecq[e0] - rdq[r0], 3);
    check("t1_wr_lat", wcq[o0] - ecq[e0], 6);

    // illegal id 7 with 2 payload beats, then legal job on engine 2
    r0 = rdq.size(); e0 = enq.size(); o0 = oq.size(); i0 = ill_n;
    done_dly = 3; done_res = res2;
    fq.push_back(hdr(3'd7, 2'd1, 1'b0));
    fq.push_back(48'hBAD0_0000_0001);
    fq.push_back(48'hBAD0_0000_0002);
    fq.push_back(hdr(3'd2, 2'd0, 1'b0));
    fq.push_back(48'h0000_0000_0B01);
    wait_wr(o0 + 1, 80);
    wait_idle(20);
    check("t2_ill_n", ill_n - i0, 1);
    check("t2_en_n", enq.size() - e0, 1);
    check("t2_en", enq[e0], 6'b000100);
    check("t2_op", eopq[e0], {144'd0, 48'h0000_0000_0B01});
    check("t2_rd_n", rdq.size() - r0, 5);
    check("t2_out", oq[o0], res2[47:0]);

    // timeout on engine 1; a done from engine 3 meanwhile is ignored
    e0 = enq.size(); o0 = oq.size(); t0 = to_n;
    auto_done = 1'b0;
    fq.push_back(hdr(3'd1, 2'd0, 1'b0));
    fq.push_back(48'h0000_0000_0101);
    wait_en(e0 + 1, 40);
    stray_cyc = cyc + 3; stray_mask = 6'b001000; stray_res = {48'h0, 48'h0000_0BAD_0BAD};
    for (int k = 0; k < 40 && to_n == t0; k++) step();
    step(); step();
    check("t3_to_n", to_n - t0, 1);
    check("t3_to_cyc", to_cyc - ecq[e0], 16);
    check("t3_busy_fall", fall_cyc - to_cyc, 1);
    check("t3_wr_n", oq.size() - o0, 0);
    check("t3_busy", busy, 0);

    // 2-beat result with out_full held for the first 3 EMIT cycles
    e0 = enq.size(); o0 = oq.size();
    auto_done = 1'b1; done_dly = 2; done_res = res4;
    fq.push_back(hdr(3'd4, 2'd0, 1'b1));
    fq.push_back(48'h0000_0000_0404);
    wait_en(e0 + 1, 40);
    out_full = 1'b1;
    for (int k = 0; k < 20 && cyc < ecq[e0] + 6; k++) step();
    out_full = 1'b0;
    wait_wr(o0 + 2, 20);
    wait_idle(20);
    check("t4_wr_n", oq.size() - o0, 2);
    check("t4_hi", oq[o0], 48'hAAAA_BBBB_CCCC);
    check("t4_lo", oq[o0 + 1], 48'h1111_2222_3333);
    check("t4_wr_cyc", wcq[o0] - ecq[e0], 6);
    check("t4_wr_gap", wcq[o0 + 1] - wcq[o0], 1);

    // 4-beat payload with empty toggling, followed by another queued job
    r0 = rdq.size(); e0 = enq.size(); o0 = oq.size();
    done_dly = 2; done_res = res5a;
    toggle_mode = 1'b1;
    fq.push_back(hdr(3'd5, 2'd3, 1'b0));
    fq.push_back(48'h0A0A_0000_0001);
    fq.push_back(48'h0A0A_0000_0002);
    fq.push_back(48'h0A0A_0000_0003);
    fq.push_back(48'h0A0A_0000_0004);
    fq.push_back(hdr(3'd3, 2'd0, 1'b0));
    fq.push_back(48'h0000_0000_0303);
    wait_en(e0 + 1, 60);
    done_res = res5b;
    wait_wr(o0 + 2, 80);
    wait_idle(20);
    toggle_mode = 1'b0;
    check("t5_en", enq[e0], 6'b100000);
    check("t5_op", eopq[e0], {48'h0A0A_0000_0001, 48'h0A0A_0000_0002,
                              48'h0A0A_0000_0003, 48'h0A0A_0000_0004});
    check("t5_rd_at_en", rd_at_en[e0] - r0, 5);
    check("t5_en_lat", ecq[e0] - rdq[r0 + 4], 2);
    check("t5_out0", oq[o0], res5a[47:0]);
    check("t5_en2", enq[e0 + 1], 6'b001000);
    check("t5_out1", oq[o0 + 1], res5b[47:0]);

    // reset during WAIT, late done after release, then a normal job
    e0 = enq.size(); o0 = oq.size();
    auto_done = 1'b0;
    fq.push_back(hdr(3'd2, 2'd0, 1'b0));
    fq.push_back(48'h0000_0000_0202);
    wait_en(e0 + 1, 40);
    step(); step();
    check("t6_in_wait", busy, 1);
    rstn = 1'b1;
    step(); step();
    check("t6_rst_ctrl", {eng_en, op_sel, out_wren, busy, err_illegal, err_timeout, fifo_rden}, 0);
    check("t6_rst_op", op_data, 0);
    check("t6_rst_out", out_data, 0);
    rstn = 1'b0;
    stray_cyc = cyc + 2; stray_mask = 6'b000100; stray_res = {48'h0, 48'h0000_0DEA_D000};
    for (int k = 0; k < 6; k++) step();
    check("t6_late_wr", oq.size() - o0, 0);
    check("t6_idle", busy, 0);
    auto_done = 1'b1; done_dly = 3; done_res = res6;
    fq.push_back(hdr(3'd2, 2'd0, 1'b0));
    fq.push_back(p6);
    wait_wr(o0 + 1, 60);
    wait_idle(20);
    check("t6_en", enq[e0 + 1], 6'b000100);
    check("t6_op", eopq[e0 + 1], {144'd0, p6});
    check("t6_out", oq[o0], res6[47:0]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Sequences the float/fixed converter bank (six engines: 3 float->fixed, 3 fixed->float) from one 48-bit command FIFO.
- Parses a header word, gathers payload beats into an operand register and launches exactly one engine with a one-cycle enable.
- Waits for that engine's done, with a timeout, then streams the result to an output FIFO with full backpressure.
- One job in flight at a time; sits between the input FIFO and the engine bank / result FIFO.

Parameters:
- TIMEOUT, 1024, number of WAIT cycles without done before the job is abandoned (>=2).
- TO_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, synchronous, active-high (1 = reset asserted).
- fifo_dout  in  48  input FIFO read data; valid the cycle after fifo_rden.
- fifo_empty  in  1  input FIFO empty.
- fifo_rden  out  1  input FIFO read strobe.
- op_data  out  192  operand to engines; stable from FIRE until the job leaves WAIT.
- op_sel  out  3  active engine id; drives the external result mux.
- eng_en  out  6  one-hot launch pulse, one cycle.
- eng_done  in  6  per-engine done pulse.
- res_data  in  96  muxed result of engine op_sel; valid while its done is high.
- out_data  out  48  result beat.
- out_wren  out  1  output FIFO write strobe.
- out_full  in  1  output FIFO full.
- busy  out  1  high in any state except IDLE.
- err_illegal  out  1  one-cycle pulse: job had an illegal engine id.
- err_timeout  out  1  one-cycle pulse: job timed out.

Behaviour:
- Header word format:
  - [47:45] engine id; 0-5 legal, 6-7 illegal.
  - [44:43] payload beats minus 1 (1..4 beats).
  - [42] result beats minus 1 (1..2 beats).
  - [41:0] ignored.
- Reset: state IDLE; all outputs, op_data, counters and flags are 0. Reset mid-job abandons the job. An engine done arriving after reset is ignored.
- FIFO reads:
  - fifo_rden is asserted only when !fifo_empty and a beat is still needed.
  - A registered rd_valid flag marks the data cycle one cycle after each read.
  - The block never reads beyond the current job's beats.
- States:
  - IDLE: fifo_rden = !fifo_empty. On rd_valid go to HDR capture.
  - HDR: latch id, pbeats, rbeats; clear op_data to 0; set op_sel = id. Reads for the first payload beat may issue in the same cycle the header is captured.
  - LOAD: each rd_valid does op_data <= {op_data[143:0], fifo_dout}, so the last beat lands in [47:0]. Empty gaps stall without corruption. After the final beat: legal id -> FIRE; illegal id -> pulse err_illegal -> IDLE, with no eng_en and all its payload beats consumed.
  - FIRE: eng_en[id] = 1 for exactly one cycle; clear the timeout counter -> WAIT.
  - WAIT:
    - eng_done[id] = 1 -> capture res_data -> EMIT.
    - Otherwise the counter increments; when it reaches TIMEOUT, pulse err_timeout -> IDLE.
    - If done and the limit coincide, done wins.
    - done on any other engine is ignored.
  - EMIT:
    - Write the result beats with out_wren = !out_full; a beat advances only when written.
    - 2 beats: res[95:48] first, then res[47:0]. 1 beat: res[47:0].
    - -> IDLE after the last write.
- Latency: with header and a 1-beat payload present at cycle 0:
  - header read c0, captured c1;
  - payload read c1, data c2;
  - eng_en c3;
  - done at cycle t -> first out_wren at t+1 when not full.
- Back-to-back: after EMIT (or an error) the next header read issues in the IDLE cycle that follows.
- busy = 0 only in IDLE.

Test Plan:
- Single job: header id 0, 1 payload beat, 1 result beat; payload 0x0000_3FC0_0000 (1.5f); engine 0 raises done 5 cycles after eng_en with res 0x...0001_8000 -> eng_en=6'b000001 for one cycle; op_data[47:0]=0x00003FC00000; one out_wren with out_data=0x000000018000.
- Illegal id 7 with 2 payload beats, followed by a legal job on id 2 -> both payload beats consumed; err_illegal one pulse; eng_en stays 0; next job fires eng_en=6'b000100.
- TIMEOUT=16, id 1 job with no done -> err_timeout pulses on the 16th WAIT cycle; busy falls next cycle; a done from engine 3 during WAIT has no effect.
- 2-beat result with out_full high for 3 cycles at EMIT start, then low -> no writes while full; then res[95:48] and res[47:0] in order, exactly 2 writes.
- 4-beat payload with fifo_empty toggling every other cycle -> op_data = {b0,b1,b2,b3}; no extra reads; eng_en follows the last beat.
- rstn asserted during WAIT, and engine done arrives 2 cycles after release -> all outputs 0 after reset; the late done produces no out_wren; the next header is processed normally.
